// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared opcodes, parser states and defaults for cmd_parser (state set depends on CMD_CHECKSUM_EN)
package cmd_pkg;

  localparam int NUM_CHANNELS_DEF = 128;

  localparam logic [7:0] OP_SET_PHASE = 8'h01;
  localparam logic [7:0] OP_COMMIT    = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_PHASE = 3'd2,
`ifdef CMD_CHECKSUM_EN
    ST_CHK   = 3'd3,
`endif
    ST_EXEC  = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

endpackage

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - byte-stream command parser driving shadow phase bank writes and commits (CMD_CHECKSUM_EN adds an XOR trailer byte)
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int PHASE_WIDTH  = 8
) (
  input  logic                            sys_clk,
  input  logic                            ext_rst,
  input  logic [7:0]                      rxfifo_data,
  input  logic                            rxfifo_empty,
  output logic                            rxfifo_rdreq,
  output logic                            phase_we,
  output logic [$clog2(NUM_CHANNELS)-1:0] phase_addr,
  output logic [PHASE_WIDTH-1:0]          phase_data,
  output logic                            phase_commit,
  output logic                            busy,
  output logic [7:0]                      err_cnt
);

  localparam int AW = $clog2(NUM_CHANNELS);

  // State reached once the opcode / payload is complete: checksum byte or straight to execution.
`ifdef CMD_CHECKSUM_EN
  localparam state_t ST_POST = ST_CHK;
`else
  localparam state_t ST_POST = ST_EXEC;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_op;
  logic [7:0]      r_addr;
  logic [7:0]      r_phase;
  logic [AW-1:0]   r_clr_cnt;
  logic [7:0]      r_err_cnt;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]      r_xor;
`endif

  logic            w_rdreq;
  logic            w_we;
  logic            w_commit;
  logic            w_err;
  logic            w_addr_ok;

  assign w_addr_ok = (32'(r_addr) < 32'(NUM_CHANNELS));

  // Next state and per-cycle strobes; reset forces everything quiet so no write leaks out.
  always_comb begin
    w_next   = r_state;
    w_rdreq  = 1'b0;
    w_we     = 1'b0;
    w_commit = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rxfifo_empty) begin
          w_rdreq = 1'b1;
          case (rxfifo_data)
            OP_SET_PHASE:         w_next = ST_ADDR;
            OP_COMMIT, OP_CLEAR:  w_next = ST_POST;
            default:              w_err  = 1'b1;
          endcase
        end
      end
      ST_ADDR: begin
        if (!rxfifo_empty) begin
          w_rdreq = 1'b1;
          w_next  = ST_PHASE;
        end
      end
      ST_PHASE: begin
        if (!rxfifo_empty) begin
          w_rdreq = 1'b1;
          w_next  = ST_POST;
        end
      end
`ifdef CMD_CHECKSUM_EN
      ST_CHK: begin
        if (!rxfifo_empty) begin
          w_rdreq = 1'b1;
          if (rxfifo_data == r_xor) begin
            w_next = ST_EXEC;
          end else begin
            w_err  = 1'b1;
            w_next = ST_IDLE;
          end
        end
      end
`endif
      ST_EXEC: begin
        w_next = (r_op == OP_CLEAR) ? ST_CLEAR : ST_IDLE;
        if (r_op == OP_SET_PHASE) begin
          if (w_addr_ok) w_we  = 1'b1;
          else           w_err = 1'b1;
        end
        if (r_op == OP_COMMIT) w_commit = 1'b1;
      end
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_clr_cnt == AW'(NUM_CHANNELS - 1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (ext_rst) begin
      w_next   = ST_IDLE;
      w_rdreq  = 1'b0;
      w_we     = 1'b0;
      w_commit = 1'b0;
      w_err    = 1'b0;
    end
  end

  // State register, payload capture, clear sweep counter and saturating error count.
  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      r_state   <= ST_IDLE;
      r_op      <= 8'h00;
      r_addr    <= 8'h00;
      r_phase   <= 8'h00;
      r_clr_cnt <= '0;
      r_err_cnt <= 8'h00;
`ifdef CMD_CHECKSUM_EN
      r_xor     <= 8'h00;
`endif
    end else begin
      r_state <= w_next;
      if (w_rdreq) begin
        case (r_state)
          ST_IDLE:  r_op    <= rxfifo_data;
          ST_ADDR:  r_addr  <= rxfifo_data;
          ST_PHASE: r_phase <= rxfifo_data;
          default:  ;
        endcase
`ifdef CMD_CHECKSUM_EN
        r_xor <= (r_state == ST_IDLE) ? rxfifo_data : (r_xor ^ rxfifo_data);
`endif
      end
      if (r_state == ST_EXEC)       r_clr_cnt <= '0;
      else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Output mapping: the clear sweep overrides the latched address/phase with index/zero.
  always_comb begin
    rxfifo_rdreq = w_rdreq;
    phase_we     = w_we;
    phase_commit = w_commit;
    busy         = (r_state != ST_IDLE);
    err_cnt      = r_err_cnt;
    if (r_state == ST_CLEAR) begin
      phase_addr = r_clr_cnt;
      phase_data = '0;
    end else begin
      phase_addr = AW'(r_addr);
      phase_data = PHASE_WIDTH'(r_phase);
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - directed self-checking bench for cmd_parser, with or without CMD_CHECKSUM_EN
module tb_cmd_parser;

`ifdef CMD_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       ext_rst = 1'b1;
  logic [7:0] rxfifo_data = 8'h00;
  logic       rxfifo_empty = 1'b1;
  logic       rxfifo_rdreq;
  logic       phase_we;
  logic [6:0] phase_addr;
  logic [7:0] phase_data;
  logic       phase_commit;
  logic       busy;
  logic [7:0] err_cnt;

  cmd_parser dut (
    .sys_clk      (sys_clk),
    .ext_rst      (ext_rst),
    .rxfifo_data  (rxfifo_data),
    .rxfifo_empty (rxfifo_empty),
    .rxfifo_rdreq (rxfifo_rdreq),
    .phase_we     (phase_we),
    .phase_addr   (phase_addr),
    .phase_data   (phase_data),
    .phase_commit (phase_commit),
    .busy         (busy),
    .err_cnt      (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] fifo_q[$];
  logic [6:0] we_addrs[$];
  logic [7:0] we_datas[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int we_cnt, commit_cnt, busy_cnt, rdreq_cnt;
  int last_pop_cyc, first_we_cyc, last_we_cyc;
  int viol_empty_pop = 0;
  int viol_we_commit = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    we_cnt = 0; commit_cnt = 0; busy_cnt = 0; rdreq_cnt = 0;
    last_pop_cyc = -1; first_we_cyc = -1; last_we_cyc = -1;
    we_addrs.delete();
    we_datas.delete();
  endtask

  // Called at the falling edge: present FIFO head, observe, model the pop, advance one cycle.
  task automatic tick();
    rxfifo_empty = (fifo_q.size() == 0);
    rxfifo_data  = rxfifo_empty ? 8'h00 : fifo_q[0];
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (phase_commit) commit_cnt++;
    if (phase_we && phase_commit) viol_we_commit++;
    if (phase_we) begin
      we_cnt++;
      we_addrs.push_back(phase_addr);
      we_datas.push_back(phase_data);
      if (first_we_cyc < 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
    end
    if (rxfifo_rdreq) begin
      rdreq_cnt++;
      if (rxfifo_empty) viol_empty_pop++;
      else begin
        void'(fifo_q.pop_front());
        last_pop_cyc = cyc;
      end
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    ext_rst = 1'b1;
    ticks(2);
    ext_rst = 1'b0;
  endtask

  task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    logic [7:0] x;
    x = b0;
    fifo_q.push_back(b0);
    if (n > 1) begin fifo_q.push_back(b1); x = x ^ b1; end
    if (n > 2) begin fifo_q.push_back(b2); x = x ^ b2; end
    if (CK == 1) fifo_q.push_back(x);
  endtask

  initial begin
    int bad;
    @(negedge sys_clk);
    clear_stats();
    do_reset();

    tick();
    check("rst_rdreq",  32'(rxfifo_rdreq), 32'd0);
    check("rst_we",     32'(phase_we),     32'd0);
    check("rst_commit", 32'(phase_commit), 32'd0);
    check("rst_busy",   32'(busy),         32'd0);
    check("rst_addr",   32'(phase_addr),   32'd0);
    check("rst_data",   32'(phase_data),   32'd0);
    check("rst_err",    32'(err_cnt),      32'd0);

    // SET_PHASE 01 05 7F
    clear_stats();
    push_pkt(8'h01, 8'h05, 8'h7F, 3);
    ticks(8);
    check("set_we_cnt", 32'(we_cnt), 32'd1);
    check("set_addr",   32'(we_addrs[0]), 32'd5);
    check("set_data",   32'(we_datas[0]), 32'h7F);
    check("set_lat",    32'(last_we_cyc - last_pop_cyc), 32'd1);
    check("set_err",    32'(err_cnt), 32'd0);
    check("set_idle",   32'(busy), 32'd0);

    // COMMIT 02
    clear_stats();
    push_pkt(8'h02, 8'h00, 8'h00, 1);
    ticks(5);
    check("com_cnt",  32'(commit_cnt), 32'd1);
    check("com_busy", 32'(busy_cnt), 32'(1 + CK));
    check("com_we",   32'(we_cnt), 32'd0);

    // CLEAR 03: full sweep of zero writes
    clear_stats();
    push_pkt(8'h03, 8'h00, 8'h00, 1);
    ticks(140);
    check("clr_we_cnt", 32'(we_cnt), 32'd128);
    bad = 0;
    for (int i = 0; i < we_addrs.size(); i++)
      if (we_addrs[i] !== 7'(i) || we_datas[i] !== 8'h00) bad++;
    check("clr_seq",    32'(bad), 32'd0);
    check("clr_consec", 32'(last_we_cyc - first_we_cyc), 32'd127);
    check("clr_rdreq",  32'(rdreq_cnt), 32'(1 + CK));
    check("clr_commit", 32'(commit_cnt), 32'd0);
    check("clr_idle",   32'(busy), 32'd0);

    // Bad opcode, then out-of-range address 128
    clear_stats();
    fifo_q.push_back(8'hFF);
    push_pkt(8'h01, 8'h80, 8'h10, 3);
    ticks(10);
    check("bad_we",  32'(we_cnt), 32'd0);
    check("bad_err", 32'(err_cnt), 32'd2);

    // Highest legal address
    clear_stats();
    push_pkt(8'h01, 8'h7F, 8'hAB, 3);
    ticks(8);
    check("top_we",   32'(we_cnt), 32'd1);
    check("top_addr", 32'(we_addrs[0]), 32'h7F);
    check("top_data", 32'(we_datas[0]), 32'hAB);
    check("top_err",  32'(err_cnt), 32'd2);

    // Packet split by empty FIFO gaps
    clear_stats();
    fifo_q.push_back(8'h01);
    ticks(4);
    fifo_q.push_back(8'h22);
    ticks(4);
    check("gap_busy", 32'(busy), 32'd1);
    fifo_q.push_back(8'h33);
    if (CK == 1) fifo_q.push_back(8'h10);
    ticks(6);
    check("gap_we",   32'(we_cnt), 32'd1);
    check("gap_addr", 32'(we_addrs[0]), 32'h22);
    check("gap_data", 32'(we_datas[0]), 32'h33);

`ifdef CMD_CHECKSUM_EN
    do_reset();
    clear_stats();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h05); fifo_q.push_back(8'h7F); fifo_q.push_back(8'h7B);
    ticks(8);
    check("ck_ok_we",  32'(we_cnt), 32'd1);
    check("ck_ok_err", 32'(err_cnt), 32'd0);
    clear_stats();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h05); fifo_q.push_back(8'h7F); fifo_q.push_back(8'h00);
    ticks(8);
    check("ck_bad_we",  32'(we_cnt), 32'd0);
    check("ck_bad_err", 32'(err_cnt), 32'd1);
    check("ck_bad_idle", 32'(busy), 32'd0);
`endif

    // Reset mid-packet discards the partial packet
    do_reset();
    clear_stats();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h05);
    ticks(12);
    check("mid_busy", 32'(busy), 32'd1);
    ext_rst = 1'b1;
    tick();
    ext_rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    fifo_q.push_back(8'h7F);
    ticks(5);
    check("mid_we",  32'(we_cnt), 32'd0);
    check("mid_err", 32'(err_cnt), 32'd1);
    check("mid_q",   32'(fifo_q.size()), 32'd0);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 254; i++) fifo_q.push_back(8'hFF);
    ticks(258);
    check("sat_254", 32'(err_cnt), 32'd254);
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hEE);
    ticks(8);
    check("sat_255", 32'(err_cnt), 32'd255);

    check("no_empty_pop",  32'(viol_empty_pop), 32'd0);
    check("no_we_with_cm", 32'(viol_we_commit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter NUM_CHANNELS, default 128: number of transducer channels addressable.
REQ-002 Parameter PHASE_WIDTH, default 8: width of one phase word.
REQ-003 sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 ext_rst  input  1  reset, synchronous, active-high.
REQ-005 rxfifo_data  input  8  head byte of the show-ahead RX FIFO; valid while rxfifo_empty is low.
REQ-006 rxfifo_empty  input  1  RX FIFO empty flag.
REQ-007 rxfifo_rdreq  output  1  pops one byte; asserted only when rxfifo_empty is low.
REQ-008 phase_we  output  1  one-cycle write strobe to the shadow phase bank.
REQ-009 phase_addr  output  clog2(NUM_CHANNELS)  channel index for phase_we.
REQ-010 phase_data  output  PHASE_WIDTH  phase value for phase_we.
REQ-011 phase_commit  output  1  one-cycle pulse; copies the shadow bank to the active bank.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 err_cnt  output  8  count of rejected packets; saturates at 255.

Function
REQ-014 Packet = opcode byte, then payload: 0x01 SET_PHASE (addr byte, phase byte); 0x02 COMMIT (none); 0x03 CLEAR (none).
REQ-015 States: IDLE, ADDR, PHASE, CHK, EXEC, CLEAR; one byte is consumed per cycle with rdreq = !rxfifo_empty in IDLE/ADDR/PHASE/CHK.
REQ-016 IDLE pops the opcode: 0x01 -> ADDR; 0x02/0x03 -> CHK if checksum is enabled, else EXEC; any other value -> IDLE, err_cnt+1.
REQ-017 ADDR latches the address byte -> PHASE; PHASE latches the phase byte -> CHK if checksum is enabled, else EXEC.
REQ-018 EXEC lasts exactly one cycle, pops nothing, and then returns to IDLE (or enters CLEAR).
REQ-019 SET_PHASE: phase_we is high in the EXEC cycle, i.e. one cycle after the last byte is popped.
REQ-020 SET_PHASE with address >= NUM_CHANNELS: no phase_we; err_cnt+1.
REQ-021 COMMIT: phase_commit is high in the EXEC cycle.
REQ-022 CLEAR: from EXEC enter CLEAR and issue phase_we with data 0 at addresses 0..NUM_CHANNELS-1 on consecutive cycles, rdreq low, then IDLE. No commit is implied.
REQ-023 FIFO empty mid-packet: the state holds with no timeout; the packet resumes when bytes arrive.
REQ-024 phase_data carries the low PHASE_WIDTH bits of the phase byte, zero-extended if PHASE_WIDTH > 8.
REQ-025 err_cnt saturates at 255, with no wrap.
REQ-026 phase_we and phase_commit are never high in the same cycle.

Reset
REQ-027 When ext_rst is high on a clock edge: state IDLE; rxfifo_rdreq, phase_we, phase_commit and busy = 0; phase_addr and phase_data = 0; err_cnt = 0.
REQ-028 Reset mid-packet or mid-CLEAR aborts the operation; partially received bytes are discarded and no write or commit is issued.

Configuration
REQ-029 Macro CMD_CHECKSUM_EN defined: each packet carries one trailing byte equal to the XOR of all preceding bytes of the packet, consumed in CHK.
REQ-030 With CMD_CHECKSUM_EN, a mismatch drops the packet (no write, commit or clear), increments err_cnt, and returns the FSM to IDLE.
REQ-031 Without CMD_CHECKSUM_EN: the CHK state and trailing byte do not exist; the packet lengths are 3/1/1 bytes.

Structure
REQ-032 Shared package cmd_pkg holds: the opcode constants (OP_SET_PHASE=0x01, OP_COMMIT=0x02, OP_CLEAR=0x03), the state enum typedef, and the default for NUM_CHANNELS.
REQ-033 The design is one flat module with no sub-module; the phase banks live downstream and are outside this block.

Verification
REQ-034 FIFO bytes 01 05 7F, no checksum -> exactly one phase_we cycle with addr=5, data=0x7F, one cycle after the 7F pop; err_cnt=0.
REQ-035 Bytes 02 -> one phase_commit pulse; busy high for exactly the EXEC cycle.
REQ-036 Bytes 03 -> 128 consecutive phase_we, addr 0..127, data 0; rdreq low throughout; then IDLE.
REQ-037 Bytes FF, then 01 80 10 (addr 128) -> no phase_we; err_cnt=2.
REQ-038 With CMD_CHECKSUM_EN, bytes 01 05 7F 7B -> write accepted; bytes 01 05 7F 00 -> no write and err_cnt=1.
REQ-039 Bytes 01 05, FIFO empty 10 cycles, ext_rst pulse, then 7F -> no phase_we; 7F is parsed as an opcode and err_cnt=1.
